fir_mac_sequencer: RTL and testbench



---
 rtl/fir_mac_sequencer_if.sv | 43 ++++
 rtl/fir_mac_sequencer.sv | 105 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Bus between the FIR MAC sequencer and its tap line / coefficient store / consumer.
// slave: the sequencer side. master: the environment driving samples and data.
interface fir_mac_sequencer_if #(
    parameter int unsigned NUM_TAPS = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 2 * DATA_W + 4
);
    localparam int unsigned SEL_W = $clog2(NUM_TAPS);

    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] tap_data;
    logic [DATA_W-1:0] coef_data;
    logic [SEL_W-1:0]  tap_sel;
    logic [ACC_W-1:0]  y;
    logic              y_valid;
    logic              busy;
    logic              overrun;

    modport slave (
        input  enable,
        input  sample_valid,
        input  tap_data,
        input  coef_data,
        output tap_sel,
        output y,
        output y_valid,
        output busy,
        output overrun
    );

    modport master (
        output enable,
        output sample_valid,
        output tap_data,
        output coef_data,
        input  tap_sel,
        input  y,
        input  y_valid,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR multiply-accumulate: one tap per enabled cycle, result on y with a
// one-cycle y_valid pulse. Define FIR_SEQ_SIGNED_EN for two's-complement arithmetic;
// by default all arithmetic is unsigned.
module fir_mac_sequencer #(
    parameter int unsigned NUM_TAPS = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 2 * DATA_W + 4
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_mac_sequencer_if.slave      bus
);
    localparam int unsigned SelW     = $clog2(NUM_TAPS);
    localparam int unsigned ProdW    = 2 * DATA_W;
    localparam logic [SelW-1:0] LastSel = SelW'(NUM_TAPS - 1);

    typedef enum logic {StIdle, StMac} state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   tap_sel_q, tap_sel_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              overrun_q, overrun_d;

    logic [ProdW-1:0]  prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_sum;

`ifdef FIR_SEQ_SIGNED_EN
    // Sign-extend operands to full product width; low ProdW bits are the exact product.
    assign prod     = $signed({{DATA_W{bus.tap_data[DATA_W-1]}}, bus.tap_data})
                    * $signed({{DATA_W{bus.coef_data[DATA_W-1]}}, bus.coef_data});
    assign prod_ext = {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
`else
    assign prod     = {{DATA_W{1'b0}}, bus.tap_data} * {{DATA_W{1'b0}}, bus.coef_data};
    assign prod_ext = {{(ACC_W - ProdW){1'b0}}, prod};
`endif

    // Two's-complement add gives the same bits for signed and unsigned sums.
    assign acc_sum = acc_q + prod_ext;

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            tap_sel_q <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_sel_q <= tap_sel_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: accept samples in IDLE, step one tap per enabled MAC cycle.
    always_comb begin
        state_d   = state_q;
        tap_sel_d = tap_sel_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        overrun_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A sample arriving while disabled is simply ignored.
                if (bus.sample_valid && bus.enable) begin
                    state_d   = StMac;
                    tap_sel_d = '0;
                    acc_d     = '0;
                end
            end
            StMac: begin
                if (bus.enable && (tap_sel_q == LastSel)) begin
                    y_d       = acc_sum;
                    y_valid_d = 1'b1;
                    tap_sel_d = '0;
                    acc_d     = '0;
                    // A sample on the final edge starts the next pass back-to-back.
                    state_d   = bus.sample_valid ? StMac : StIdle;
                end else begin
                    if (bus.enable) begin
                        acc_d     = acc_sum;
                        tap_sel_d = tap_sel_q + 1'b1;
                    end
                    overrun_d = bus.sample_valid;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.tap_sel = tap_sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = (state_q == StMac);
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: table of tap/coef sets with expected y,
// plus directed sequences for overrun, back-to-back samples, enable stalls and reset.
module tb_fir_mac_sequencer;
    localparam int unsigned NT = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2 * DW + 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.NUM_TAPS(NT), .DATA_W(DW), .ACC_W(AW)) bus ();

    fir_mac_sequencer #(.NUM_TAPS(NT), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Tap line and coefficient store models, read combinationally by tap_sel.
    logic [DW-1:0] tap_mem  [NT];
    logic [DW-1:0] coef_mem [NT];
    assign bus.tap_data  = tap_mem[bus.tap_sel];
    assign bus.coef_data = coef_mem[bus.tap_sel];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Cycle counter, y_valid/busy/overrun monitor and scoreboard.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_q [$];
    int yv_cyc_q [$];
    int yv_count = 0;
    int busy_cnt = 0;
    int ovr_cnt = 0;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.overrun) ovr_cnt++;
        if (bus.y_valid) begin
            yv_count++;
            yv_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_y_valid actual=%0h required=none", bus.y);
            end else begin
                check("y_value", 64'(bus.y), 64'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        string        name;
        logic [63:0]  taps;
        logic [63:0]  coefs;
        logic [AW-1:0] y;
    } vec_t;

    vec_t vecs [6];
    int   e_cyc;

    task automatic load(input logic [63:0] t, input logic [63:0] c);
        for (int i = 0; i < NT; i++) begin
            tap_mem[i]  = t[i*DW +: DW];
            coef_mem[i] = c[i*DW +: DW];
        end
    endtask

    // Caller sits #1 after a rising edge; the next edge is the sampling edge.
    task automatic start_sample();
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        e_cyc = cyc;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_yv(output bit ok);
        int start;
        start = yv_count;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (yv_count != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL y_valid_timeout actual=none required=pulse");
        end
    endtask

    task automatic check_latency(input string name, input int exp_lat);
        int c;
        if (yv_cyc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=none required=%0d", name, exp_lat);
        end else begin
            c = yv_cyc_q.pop_front();
            check(name, 64'(c - e_cyc), 64'(exp_lat));
        end
    endtask

    initial begin
        bit ok;
        int ovr0, yv0, first_c, second_c;

        vecs[0] = '{"ramp_unity",   64'h0807060504030201, 64'h0101010101010101, AW'(36)};
        vecs[1] = '{"ramp_reverse", 64'h0807060504030201, 64'h0102030405060708, AW'(120)};
        vecs[2] = '{"all_zero",     64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, AW'(0)};
        vecs[3] = '{"twos_threes",  64'h0202020202020202, 64'h0303030303030303, AW'(48)};
        vecs[4] = '{"neg128_sq",    64'h8080808080808080, 64'h8080808080808080, AW'(131072)};
`ifdef FIR_SEQ_SIGNED_EN
        vecs[5] = '{"neg1_by_one",  64'hFFFFFFFFFFFFFFFF, 64'h0101010101010101, AW'(-8)};
`else
        vecs[5] = '{"full_scale",   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, AW'(520200)};
`endif

        bus.enable       = 1'b1;
        bus.sample_valid = 1'b0;
        load(vecs[0].taps, vecs[0].coefs);

        // Reset state, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_y", 64'(bus.y), 64'd0);
        check("rst_y_valid", 64'(bus.y_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        check("rst_tap_sel", 64'(bus.tap_sel), 64'd0);
        step(2);
        reset = 1'b0;

        // Table vectors: value, latency and busy duration.
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].taps, vecs[v].coefs);
            exp_q.push_back(vecs[v].y);
            busy_cnt = 0;
            start_sample();
            wait_yv(ok);
            check_latency({vecs[v].name, "_latency"}, 8);
            step(1);
            check({vecs[v].name, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
        end

        // Overrun: sample_valid during the 3rd MAC cycle is dropped.
        load(vecs[0].taps, vecs[0].coefs);
        exp_q.push_back(AW'(36));
        ovr0 = ovr_cnt;
        start_sample();
        step(2);
        bus.sample_valid = 1'b1;
        step(1);
        bus.sample_valid = 1'b0;
        wait_yv(ok);
        check_latency("overrun_latency", 8);
        check("overrun_pulses", 64'(ovr_cnt - ovr0), 64'd1);
        step(1);
        check("overrun_idle_after", 64'(bus.busy), 64'd0);

        // Sample on the final MAC edge starts a back-to-back pass without overrun.
        exp_q.push_back(AW'(36));
        exp_q.push_back(AW'(36));
        ovr0 = ovr_cnt;
        start_sample();
        step(7);
        bus.sample_valid = 1'b1;
        step(1);
        bus.sample_valid = 1'b0;
        wait_yv(ok);
        first_c = (yv_cyc_q.size() > 0) ? yv_cyc_q[0] : 0;
        check_latency("b2b_first_latency", 8);
        wait_yv(ok);
        second_c = (yv_cyc_q.size() > 0) ? yv_cyc_q.pop_front() : 0;
        check("b2b_spacing", 64'(second_c - first_c), 64'd8);
        check("b2b_no_overrun", 64'(ovr_cnt - ovr0), 64'd0);
        step(1);

        // Enable low for two cycles mid-MAC delays y_valid by exactly two cycles.
        exp_q.push_back(AW'(36));
        start_sample();
        step(3);
        bus.enable = 1'b0;
        step(2);
        bus.enable = 1'b1;
        wait_yv(ok);
        check_latency("stall_latency", 10);
        step(1);

        // Sample while idle and disabled is ignored silently.
        ovr0 = ovr_cnt;
        yv0 = yv_count;
        bus.enable = 1'b0;
        bus.sample_valid = 1'b1;
        step(1);
        bus.sample_valid = 1'b0;
        step(3);
        check("idle_disabled_busy", 64'(bus.busy), 64'd0);
        check("idle_disabled_overrun", 64'(ovr_cnt - ovr0), 64'd0);
        check("idle_disabled_y_valid", 64'(yv_count - yv0), 64'd0);
        bus.enable = 1'b1;

        // Reset in the 4th MAC cycle: outputs clear at once, no result for that sample.
        start_sample();
        step(3);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_y", 64'(bus.y), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_tap_sel", 64'(bus.tap_sel), 64'd0);
        check("midrst_y_valid", 64'(bus.y_valid), 64'd0);
        yv0 = yv_count;
        step(2);
        reset = 1'b0;
        load(vecs[1].taps, vecs[1].coefs);
        exp_q.push_back(AW'(120));
        start_sample();
        wait_yv(ok);
        check_latency("post_reset_latency", 8);
        check("post_reset_one_result", 64'(yv_count - yv0), 64'd1);
        step(3);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
